xp_switch_alloc: RTL and testbench

Per-router switch allocator that directly consumes the output-port decisions made by X-Y route computation. It arbitrates the five router inputs (N, S, E, W, Local) for the five outputs with per-output round-robin fairness and credit-based flow control toward the downstream buffers. It issues same-cycle grants to the input buffers and registered crossbar selects to the switch-traversal stage. All packets are single-flit; there is no wormhole locking.

---
 rtl/coh_noc_pkg.sv | 20 ++
 rtl/xp_rr_arbiter.sv | 27 ++
 rtl/xp_switch_alloc.sv | 134 +++++++++++++
 tb/tb_xp_switch_alloc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/coh_noc_pkg.sv
// Shared NoC definitions: port numbering used by route computation and switch allocation.
package coh_noc_pkg;

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_W    = 3;

    typedef enum logic [PORT_W-1:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        EAST  = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } port_e;

    // Successor port index, wrapping after LOCAL.
    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        return (p >= PORT_W'(NUM_PORTS - 1)) ? '0 : p + PORT_W'(1);
    endfunction

endpackage

// File: rtl/xp_rr_arbiter.sv
// Five-request round-robin arbiter: search starts at ptr_i and wraps; one-hot grant out.
module xp_rr_arbiter
    import coh_noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [PORT_W-1:0] idx;
    logic              found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        // An out-of-range pointer is treated as 0 so the search always covers all inputs.
        idx   = (ptr_i < PORT_W'(NUM_PORTS)) ? ptr_i : '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = port_inc(idx);
        end
    end

endmodule

// File: rtl/xp_switch_alloc.sv
// Switch allocator: per-output round-robin over routed requests with credit flow control,
// same-cycle grants to inputs and registered crossbar selects.
module xp_switch_alloc
    import coh_noc_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_PORTS-1:0]          req_valid_i,
    input  logic [NUM_PORTS*PORT_W-1:0]   req_port_i,
    input  logic [NUM_PORTS-1:0]          credit_ret_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic [NUM_PORTS-1:0]          sel_valid_o,
    output logic [NUM_PORTS*PORT_W-1:0]   sel_in_o,
    output logic [NUM_PORTS-1:0]          credit_avail_o,
    output logic                          err_bad_port_o,
    output logic                          err_credit_ovf_o
);

    localparam int unsigned      CRD_W   = 4;
    localparam logic [CRD_W-1:0] CrdInit = CRD_W'(BUF_DEPTH);

    logic [NUM_PORTS-1:0][CRD_W-1:0]     crd_q, crd_d;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    rr_q, rr_d;
    logic [NUM_PORTS-1:0]                sel_valid_q, sel_valid_d;
    logic [NUM_PORTS*PORT_W-1:0]         sel_in_q, sel_in_d;
    logic                                bad_port_q, bad_port_d;
    logic                                ovf_q, ovf_d;

    // elig[o] / gnt_oh[o] are indexed by output, bit i by input.
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] elig;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_oh;
    logic [NUM_PORTS-1:0]                out_gnt;
    logic [NUM_PORTS-1:0][PORT_W-1:0]    gnt_idx;

    always_comb begin
        elig = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                elig[o][i] = req_valid_i[i] &&
                             (req_port_i[PORT_W*i +: PORT_W] == PORT_W'(o)) &&
                             (crd_q[o] != '0);
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_arb
        xp_rr_arbiter u_arb (
            .req_i (elig[g]),
            .ptr_i (rr_q[g]),
            .gnt_o (gnt_oh[g])
        );
    end

    always_comb begin
        gnt_o   = '0;
        out_gnt = '0;
        gnt_idx = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            out_gnt[o] = |gnt_oh[o];
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (gnt_oh[o][i]) begin
                    gnt_o[i]   = 1'b1;
                    gnt_idx[o] = PORT_W'(i);
                end
            end
        end
        // Inputs must not dequeue while the allocator is held in reset.
        gnt_o = gnt_o & {NUM_PORTS{rst_ni}};
    end

    always_comb begin
        crd_d       = crd_q;
        rr_d        = rr_q;
        sel_valid_d = '0;
        sel_in_d    = sel_in_q;
        ovf_d       = ovf_q;
        bad_port_d  = 1'b0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            if (out_gnt[o]) begin
                rr_d[o]                       = port_inc(gnt_idx[o]);
                sel_valid_d[o]                = 1'b1;
                sel_in_d[PORT_W*o +: PORT_W]  = gnt_idx[o];
            end
            unique case ({out_gnt[o], credit_ret_i[o]})
                2'b10: crd_d[o] = crd_q[o] - CRD_W'(1);
                2'b01: begin
                    if (crd_q[o] == CrdInit) ovf_d = 1'b1;
                    else                     crd_d[o] = crd_q[o] + CRD_W'(1);
                end
                default: crd_d[o] = crd_q[o];
            endcase
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_valid_i[i] && (req_port_i[PORT_W*i +: PORT_W] > PORT_W'(NUM_PORTS - 1))) begin
                bad_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                crd_q[o] <= CrdInit;
            end
            rr_q        <= '0;
            sel_valid_q <= '0;
            sel_in_q    <= '0;
            bad_port_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            crd_q       <= crd_d;
            rr_q        <= rr_d;
            sel_valid_q <= sel_valid_d;
            sel_in_q    <= sel_in_d;
            bad_port_q  <= bad_port_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        credit_avail_o = '0;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            credit_avail_o[o] = (crd_q[o] != '0);
        end
    end

    assign sel_valid_o      = sel_valid_q;
    assign sel_in_o         = sel_in_q;
    assign err_bad_port_o   = bad_port_q;
    assign err_credit_ovf_o = ovf_q;

endmodule

// File: tb/tb_xp_switch_alloc.sv
// Bench for xp_switch_alloc: vector table for grants/credits, scoreboard for crossbar selects,
// hand-written sequences for bad port, credit overflow and asynchronous reset.
module tb_xp_switch_alloc;

    logic        clk;
    logic        rst_n;
    logic [4:0]  req_valid;
    logic [14:0] req_port;
    logic [4:0]  credit_ret;
    logic [4:0]  gnt;
    logic [4:0]  sel_valid;
    logic [14:0] sel_in;
    logic [4:0]  credit_avail;
    logic        err_bad_port;
    logic        err_credit_ovf;

    int n_run;
    int n_fail;

    typedef struct {
        logic [4:0]  rv;
        logic [14:0] rp;
        logic [4:0]  cr;
        logic [4:0]  exp_gnt;
        logic [4:0]  exp_ca;
    } vec_t;

    typedef struct {
        logic [4:0]  sv;
        logic [14:0] si;
    } sel_t;

    vec_t        vecs[$];
    sel_t        sb[$];
    logic [14:0] si_model;

    xp_switch_alloc #(.BUF_DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_port_i       (req_port),
        .credit_ret_i     (credit_ret),
        .gnt_o            (gnt),
        .sel_valid_o      (sel_valid),
        .sel_in_o         (sel_in),
        .credit_avail_o   (credit_avail),
        .err_bad_port_o   (err_bad_port),
        .err_credit_ovf_o (err_credit_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] pp(input int p4, input int p3, input int p2, input int p1,
                                       input int p0);
        return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic add(input logic [4:0] rv, input logic [14:0] rp, input logic [4:0] cr,
                       input logic [4:0] eg, input logic [4:0] ca);
        vec_t v;
        v.rv = rv; v.rp = rp; v.cr = cr; v.exp_gnt = eg; v.exp_ca = ca;
        vecs.push_back(v);
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next one.
    task automatic run_vec(input vec_t v, input int k);
        sel_t e;
        int   o;
        req_valid  = v.rv;
        req_port   = v.rp;
        credit_ret = v.cr;
        #3;
        chk($sformatf("v%0d gnt", k), 32'(gnt), 32'(v.exp_gnt));
        chk($sformatf("v%0d credit_avail", k), 32'(credit_avail), 32'(v.exp_ca));
        e.sv = '0;
        e.si = si_model;
        for (int i = 0; i < 5; i++) begin
            if (v.exp_gnt[i]) begin
                o              = int'(v.rp[3*i +: 3]);
                e.sv[o]        = 1'b1;
                e.si[3*o +: 3] = 3'(i);
            end
        end
        si_model = e.si;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d sel_valid", k), 32'(sel_valid), 32'(e.sv));
        chk($sformatf("v%0d sel_in", k), 32'(sel_in), 32'(e.si));
        chk($sformatf("v%0d err_bad_port", k), 32'(err_bad_port), 32'd0);
        chk($sformatf("v%0d err_credit_ovf", k), 32'(err_credit_ovf), 32'd0);
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        si_model   = '0;
        rst_n      = 1'b0;
        // A request during reset must not be granted.
        req_valid  = 5'b00100;
        req_port   = pp(0, 0, 4, 0, 0);
        credit_ret = '0;
        #12;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst sel_valid", 32'(sel_valid), 32'd0);
        chk("rst sel_in", 32'(sel_in), 32'd0);
        chk("rst credit_avail", 32'(credit_avail), 32'h1f);
        chk("rst err_bad_port", 32'(err_bad_port), 32'd0);
        chk("rst err_credit_ovf", 32'(err_credit_ovf), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        add(5'b00100, pp(0, 0, 4, 0, 0), 5'b00000, 5'b00100, 5'b11111);
        add(5'b00000, 15'd0,             5'b00000, 5'b00000, 5'b11111);
        // Inputs 0,1,3 contend for East with a credit returned every cycle.
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b00001, 5'b11111);
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b00010, 5'b11111);
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b01000, 5'b11111);
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b00001, 5'b11111);
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b00010, 5'b11111);
        add(5'b01011, pp(0, 2, 0, 2, 2), 5'b00100, 5'b01000, 5'b11111);
        // Exhaust South credits, then one returned credit is usable only a cycle later.
        for (int n = 0; n < 4; n++) add(5'b00001, pp(0, 0, 0, 0, 1), 5'b0, 5'b00001, 5'b11111);
        add(5'b00001, pp(0, 0, 0, 0, 1), 5'b00000, 5'b00000, 5'b11101);
        add(5'b00001, pp(0, 0, 0, 0, 1), 5'b00010, 5'b00000, 5'b11101);
        add(5'b00001, pp(0, 0, 0, 0, 1), 5'b00000, 5'b00001, 5'b11111);
        add(5'b00000, 15'd0,             5'b00010, 5'b00000, 5'b11101);
        // Five simultaneous grants including the Local self-request.
        add(5'b11111, pp(4, 3, 2, 1, 0), 5'b00000, 5'b11111, 5'b11111);
        // West: grant + credit return in the same cycle at crd=2 keeps crd at 2.
        add(5'b01000, pp(0, 3, 0, 0, 0), 5'b00010, 5'b01000, 5'b11101);
        add(5'b01000, pp(0, 3, 0, 0, 0), 5'b01000, 5'b01000, 5'b11111);
        add(5'b01000, pp(0, 3, 0, 0, 0), 5'b00000, 5'b01000, 5'b11111);
        add(5'b01000, pp(0, 3, 0, 0, 0), 5'b00000, 5'b01000, 5'b11111);
        add(5'b01000, pp(0, 3, 0, 0, 0), 5'b00000, 5'b00000, 5'b10111);
        add(5'b00000, 15'd0,             5'b01000, 5'b00000, 5'b10111);
        add(5'b00000, 15'd0,             5'b01000, 5'b00000, 5'b11111);

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

        // Out-of-range port: never granted, error pulses for one cycle.
        req_valid  = 5'b00010;
        req_port   = pp(0, 0, 0, 6, 0);
        credit_ret = '0;
        #3;
        chk("badport gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("badport pulse", 32'(err_bad_port), 32'd1);
        chk("badport sel_valid", 32'(sel_valid), 32'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("badport clear", 32'(err_bad_port), 32'd0);

        // Credit return with a full counter sets the sticky overflow flag.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        credit_ret = 5'b00001;
        #3;
        chk("ovf pre credit_avail", 32'(credit_avail), 32'h1f);
        @(posedge clk);
        #1;
        credit_ret = '0;
        chk("ovf set", 32'(err_credit_ovf), 32'd1);
        req_valid = 5'b00001;
        req_port  = pp(0, 0, 0, 0, 0);
        for (int n = 0; n < 5; n++) begin
            #3;
            chk($sformatf("ovf gnt%0d", n), 32'(gnt), (n < 4) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        chk("ovf drained credit_avail", 32'(credit_avail), 32'h1e);
        chk("ovf sticky", 32'(err_credit_ovf), 32'd1);

        // Reset asserted mid-cycle while traffic is flowing.
        req_valid  = 5'b11111;
        req_port   = pp(4, 3, 2, 1, 0);
        credit_ret = 5'b11111;
        @(posedge clk);
        #1;
        chk("traffic sel_valid", 32'(sel_valid), 32'h1e);
        chk("traffic sel_in", 32'(sel_in), 32'(pp(4, 3, 2, 1, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async gnt", 32'(gnt), 32'd0);
        chk("async sel_valid", 32'(sel_valid), 32'd0);
        chk("async sel_in", 32'(sel_in), 32'd0);
        chk("async credit_avail", 32'(credit_avail), 32'h1f);
        chk("async err_bad_port", 32'(err_bad_port), 32'd0);
        chk("async err_credit_ovf", 32'(err_credit_ovf), 32'd0);
        req_valid  = '0;
        credit_ret = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #5;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
